// File: rtl/proc_fl_out_fifo_if.sv
// Consumer-side stream of the processor output FIFO: head entry data, address tag
// and a first-word-fall-through valid/ready handshake.
interface proc_fl_out_fifo_if #(
  parameter int NBDATA = 23,
  parameter int NBADDR = 1
);
  logic [NBDATA-1:0] m_data;
  logic [NBADDR-1:0] m_addr;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_addr, output m_valid, input m_ready);
  modport slave  (input m_data, input m_addr, input m_valid, output m_ready);
endinterface

// File: rtl/proc_fl_out_fifo.sv
// Tagged FIFO behind the floating-point processor output port: captures masked output
// writes, drains them first-word-fall-through, and reports level/full/afull/sticky overflow.
module proc_fl_out_fifo #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOOU = 2,
  parameter int DEPTH  = 8,
  parameter int AFULL  = 6,
  localparam int NBDATA = NBMANT + NBEXPO + 1,
  localparam int NBADDR = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int NBLVL  = $clog2(DEPTH) + 1,
  parameter logic [NUIOOU-1:0] ADDRMSK = {NUIOOU{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               out_en_i,
  input  logic [NBADDR-1:0]  addr_out_i,
  input  logic [NBDATA-1:0]  io_out_i,
  proc_fl_out_fifo_if.master m_if,
  output logic [NBLVL-1:0]   level_o,
  output logic               full_o,
  output logic               afull_o,
  output logic               ovf_o,
  input  logic               ovf_clr_i
);

  localparam int NBPTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBENT = NBADDR + NBDATA;

  // Addresses beyond NUIOOU never match a mask bit, so their writes are ignored.
  function automatic logic addr_enabled(input logic [NBADDR-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUIOOU; i++) begin
      if (addr == NBADDR'(i)) begin
        hit = ADDRMSK[i];
      end
    end
    return hit;
  endfunction

  logic [NBENT-1:0] mem_q [DEPTH];
  logic [NBPTR-1:0] wptr_q, wptr_d;
  logic [NBPTR-1:0] rptr_q, rptr_d;
  logic [NBLVL-1:0] level_q, level_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             push_req_s, pop_s, push_s;
  logic [NBENT-1:0] head_s;

  // Handshake decode and next-state for pointers, level, flags and overflow.
  always_comb begin
    push_req_s = out_en_i & addr_enabled(addr_out_i);
    pop_s      = valid_q & m_if.m_ready;
    push_s     = push_req_s & (~full_q | pop_s);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (push_s) begin
      wptr_d = wptr_q + NBPTR'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + NBPTR'(1);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + NBLVL'(1);
      2'b01:   level_d = level_q - NBLVL'(1);
      default: level_d = level_q;
    endcase

    // A dropped write takes priority over a clear in the same cycle.
    if (push_req_s & full_q & ~pop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    valid_d = (level_d != {NBLVL{1'b0}});
    full_d  = (level_d == NBLVL'(DEPTH));
    afull_d = (level_d >= NBLVL'(AFULL));
  end

  // Pointer, level, flag and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= {NBPTR{1'b0}};
      rptr_q  <= {NBPTR{1'b0}};
      level_q <= {NBLVL{1'b0}};
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; contents need no reset since validity is tracked by the level.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {addr_out_i, io_out_i};
    end
  end

  assign head_s       = mem_q[rptr_q];
  assign m_if.m_data  = head_s[NBDATA-1:0];
  assign m_if.m_addr  = head_s[NBENT-1:NBDATA];
  assign m_if.m_valid = valid_q;
  assign level_o      = level_q;
  assign full_o       = full_q;
  assign afull_o      = afull_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_proc_fl_out_fifo.sv
// Scoreboard bench: two FIFOs (full mask and mask 2'b10) share stimulus; each has a
// queue-based reference model and a monitor comparing outputs every cycle.
module tb_proc_fl_out_fifo;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int NBDATA = 23;
  localparam int NBADDR = 1;
  localparam int NBLVL  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst     = 1'b1;
  logic              out_en  = 1'b0;
  logic [NBADDR-1:0] addr    = '0;
  logic [NBDATA-1:0] wdata   = '0;
  logic              rdy     = 1'b0;
  logic              ovf_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam logic [1:0] MSK = (k == 0) ? 2'b11 : 2'b10;

    proc_fl_out_fifo_if #(.NBDATA(NBDATA), .NBADDR(NBADDR)) m_if ();
    logic [NBLVL-1:0] level;
    logic             full, afull, ovf;

    assign m_if.m_ready = rdy;

    proc_fl_out_fifo #(
      .NBMANT(16), .NBEXPO(6), .NUIOOU(2), .DEPTH(DEPTH), .AFULL(AFULL), .ADDRMSK(MSK)
    ) u_dut (
      .clk(clk), .rst(rst),
      .out_en_i(out_en), .addr_out_i(addr), .io_out_i(wdata),
      .m_if(m_if),
      .level_o(level), .full_o(full), .afull_o(afull), .ovf_o(ovf),
      .ovf_clr_i(ovf_clr)
    );

    // Reference model: a plain queue of accepted {addr, data} words plus the overflow flag.
    logic [NBADDR+NBDATA-1:0] exp_q[$];
    bit exp_ovf = 1'b0;

    always @(posedge clk) begin
      bit req, pop;
      req = out_en && MSK[addr];
      pop = (exp_q.size() != 0) && rdy;
      if (rst) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        if (req && exp_q.size() == DEPTH && !pop) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (req && exp_q.size() < DEPTH) exp_q.push_back({addr, wdata});
      end
    end

    // Monitor on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
      chk($sformatf("valid[%0d]", k), 64'(m_if.m_valid), 64'(exp_q.size() != 0));
      chk($sformatf("level[%0d]", k), 64'(level), 64'(exp_q.size()));
      chk($sformatf("full[%0d]", k), 64'(full), 64'(exp_q.size() == DEPTH));
      chk($sformatf("afull[%0d]", k), 64'(afull), 64'(exp_q.size() >= AFULL));
      chk($sformatf("ovf[%0d]", k), 64'(ovf), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk($sformatf("head[%0d]", k), 64'({m_if.m_addr, m_if.m_data}), 64'(exp_q[0]));
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that consumed it.
  task automatic cyc(input logic en, input logic [NBADDR-1:0] a, input logic [NBDATA-1:0] d,
                     input logic r, input logic clr, input logic rs);
    out_en = en; addr = a; wdata = d; rdy = r; ovf_clr = clr; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [NBADDR-1:0] a, input logic [NBDATA-1:0] d, input logic r);
    cyc(1'b1, a, d, r, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 1'b0, 23'h0, r, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 23'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 23'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_level", 64'(g_inst[0].level), 64'd0);
    chk("rst_valid", 64'(g_inst[0].m_if.m_valid), 64'd0);
    chk("rst_full", 64'(g_inst[0].full), 64'd0);
    chk("rst_afull", 64'(g_inst[0].afull), 64'd0);
    chk("rst_ovf", 64'(g_inst[0].ovf), 64'd0);

    // Basic order
    wr(1'b0, 23'h000001, 1'b0);
    chk("basic_valid1", 64'(g_inst[0].m_if.m_valid), 64'd1);
    wr(1'b1, 23'h7FFFFF, 1'b0);
    wr(1'b0, 23'h400000, 1'b0);
    chk("basic_level3", 64'(g_inst[0].level), 64'd3);
    chk("basic_head0", 64'({g_inst[0].m_if.m_addr, g_inst[0].m_if.m_data}), 64'({1'b0, 23'h000001}));
    idle(1'b1);
    chk("basic_head1", 64'({g_inst[0].m_if.m_addr, g_inst[0].m_if.m_data}), 64'({1'b1, 23'h7FFFFF}));
    idle(1'b1);
    chk("basic_head2", 64'({g_inst[0].m_if.m_addr, g_inst[0].m_if.m_data}), 64'({1'b0, 23'h400000}));
    idle(1'b1);
    chk("basic_empty", 64'({g_inst[0].m_if.m_valid, g_inst[0].level}), 64'd0);

    // Full and overflow
    for (int i = 1; i <= 9; i++) begin
      wr(1'b0, 23'(i + 256), 1'b0);
      if (i == 8) begin
        chk("ovf_full8", 64'(g_inst[0].full), 64'd1);
        chk("ovf_not_yet", 64'(g_inst[0].ovf), 64'd0);
      end
    end
    chk("ovf_set", 64'(g_inst[0].ovf), 64'd1);
    chk("ovf_level8", 64'(g_inst[0].level), 64'd8);
    cyc(1'b0, 1'b0, 23'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 64'(g_inst[0].ovf), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain", 64'(g_inst[0].m_if.m_data), 64'(i + 256));
      idle(1'b1);
    end
    chk("ovf_empty", 64'(g_inst[0].m_if.m_valid), 64'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) wr(1'b0, 23'(i + 512), 1'b0);
    wr(1'b1, 23'h3ABCDE, 1'b1);
    chk("pp_level8", 64'(g_inst[0].level), 64'd8);
    chk("pp_ovf0", 64'(g_inst[0].ovf), 64'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("pp_drain", 64'(g_inst[0].m_if.m_data), 64'(i + 512));
      idle(1'b1);
    end
    chk("pp_last", 64'({g_inst[0].m_if.m_addr, g_inst[0].m_if.m_data}), 64'({1'b1, 23'h3ABCDE}));
    idle(1'b1);

    // Almost-full threshold
    for (int i = 1; i <= 5; i++) wr(1'b0, 23'(i), 1'b0);
    chk("afull_at5", 64'(g_inst[0].afull), 64'd0);
    wr(1'b0, 23'h6, 1'b0);
    chk("afull_at6", 64'(g_inst[0].afull), 64'd1);
    idle(1'b1);
    chk("afull_pop5", 64'(g_inst[0].afull), 64'd0);
    wr(1'b0, 23'h7, 1'b0);
    wr(1'b0, 23'h8, 1'b0);
    chk("afull_at7", 64'(g_inst[0].afull), 64'd1);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Address mask on the second instance
    for (int j = 0; j < 4; j++) begin
      wr(1'b0, 23'(16'hA000 + j), 1'b0);
      wr(1'b1, 23'(16'hB000 + j), 1'b0);
    end
    chk("mask_level4", 64'(g_inst[1].level), 64'd4);
    chk("mask_head", 64'({g_inst[1].m_if.m_addr, g_inst[1].m_if.m_data}), 64'({1'b1, 23'hB000}));
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Reset mid-operation with overflow set
    for (int i = 1; i <= 9; i++) wr(1'b0, 23'(i + 1024), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("mid_level5", 64'(g_inst[0].level), 64'd5);
    cyc(1'b0, 1'b0, 23'h0, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_level", 64'(g_inst[0].level), 64'd0);
    chk("mid_rst_valid", 64'(g_inst[0].m_if.m_valid), 64'd0);
    chk("mid_rst_ovf", 64'(g_inst[0].ovf), 64'd0);
    wr(1'b1, 23'h012345, 1'b1);
    chk("mid_after_valid", 64'(g_inst[0].m_if.m_valid), 64'd1);
    chk("mid_after_head", 64'({g_inst[0].m_if.m_addr, g_inst[0].m_if.m_data}), 64'({1'b1, 23'h012345}));
    idle(1'b1);
    chk("mid_after_empty", 64'(g_inst[0].m_if.m_valid), 64'd0);

    // Randomized traffic with varying consumer pace
    for (int i = 0; i < 800; i++) begin
      int rpct;
      rpct = (i < 400) ? 30 : 70;
      cyc(1'($urandom_range(0, 99) < 60), 1'($urandom), 23'($urandom),
          1'($urandom_range(0, 99) < rpct), 1'($urandom_range(0, 99) < 5),
          1'($urandom_range(0, 299) == 0));
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
